// File: rtl/lc3b_types.sv
// lc3b_types: shared types and default widths for the memory-side blocks.
// Holds the arbiter state enum and the default 16-bit address/data widths.
package lc3b_types;

  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   requests   [NUM_PORTS]  one bit per requester
//   last_grant [IDX_W]      most recently granted port
//   grant      [IDX_W]      selected port (valid only with valid=1)
//   valid      [1]          at least one request present
// The search starts at last_grant+1 and wraps modulo NUM_PORTS, so the most
// recently served port has the lowest priority.
module rr_picker #(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] requests,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     grant,
  output logic                 valid
);

  // One extra bit so last_grant + offset cannot overflow before the wrap.
  logic [IDX_W:0] cand;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) cand = cand - (IDX_W+1)'(NUM_PORTS);
      if (!valid && requests[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        grant = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter funnelling NUM_PORTS requesters onto a
// single memory port, one transaction at a time.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_read/req_write [NP]       per-port command (both high = write)
//   req_byte_enable [NP][BE]      per-port write byte mask
//   req_address [NP][AW]          per-port address
//   req_wdata [NP][DW]            per-port write data
//   req_resp [NP]                 per-port completion pulse (same cycle as mem_resp)
//   req_rdata [DW]                shared read data, valid with req_resp
//   mem_read/mem_write            downstream command, from latched values only
//   mem_byte_enable/address/wdata downstream payload, from latched values only
//   mem_resp, mem_rdata           downstream completion and read data
// Optional (MEM_ARBITER_PERF_EN):
//   grant_count [NP][16]          saturating per-port grant counters
//   busy_cycles [32]              saturating count of BUSY cycles
module mem_arbiter
  import lc3b_types::*;
#(
  parameter  int NUM_PORTS  = 2,
  parameter  int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int BE_WIDTH   = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req_read,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]   req_byte_enable,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]                 req_resp,
  output logic [DATA_WIDTH-1:0]                req_rdata,
  output logic                                 mem_read,
  output logic                                 mem_write,
  output logic [BE_WIDTH-1:0]                  mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]                mem_address,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  input  logic                                 mem_resp,
  input  logic [DATA_WIDTH-1:0]                mem_rdata
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [NUM_PORTS-1:0][15:0]           grant_count,
  output logic [31:0]                          busy_cycles
`endif
);

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [IDX_W-1:0]      port;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
  } lat_t;

  arb_state_t           state_q, state_d;
  lat_t                 lat_q, lat_d;
  logic [IDX_W-1:0]     last_grant_q;
  logic [NUM_PORTS-1:0] pending;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 grant_fire;

  assign pending    = req_read | req_write;
  assign grant_fire = (state_q == IDLE) && pick_valid;

  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .requests   (pending),
    .last_grant (last_grant_q),
    .grant      (pick_idx),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (grant_fire) last_grant_q <= pick_idx;
    end
  end

  always_comb begin
    state_d         = state_q;
    lat_d           = lat_q;
    req_resp        = '0;
    req_rdata       = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    mem_address     = '0;
    mem_wdata       = '0;
    unique case (state_q)
      IDLE: begin
        // mem_resp is deliberately not looked at here: a response arriving
        // after a reset-abandoned transaction must not be forwarded.
        if (pick_valid) begin
          state_d     = BUSY;
          lat_d.wr    = req_write[pick_idx];
          lat_d.rd    = ~req_write[pick_idx];   // read+write resolves to write
          lat_d.port  = pick_idx;
          lat_d.addr  = req_address[pick_idx];
          lat_d.wdata = req_wdata[pick_idx];
          lat_d.be    = req_byte_enable[pick_idx];
        end
      end
      BUSY: begin
        mem_read        = lat_q.rd;
        mem_write       = lat_q.wr;
        mem_byte_enable = lat_q.be;
        mem_address     = lat_q.addr;
        mem_wdata       = lat_q.wdata;
        if (mem_resp) begin
          req_resp[lat_q.port] = 1'b1;
          req_rdata            = mem_rdata;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count <= '0;
      busy_cycles <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant_fire && pick_idx == IDX_W'(p) && grant_count[p] != 16'hFFFF)
          grant_count[p] <= grant_count[p] + 16'd1;
      end
      if (state_q == BUSY && busy_cycles != 32'hFFFF_FFFF)
        busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (4 ports, 16-bit address/data).
// With MEM_ARBITER_PERF_EN defined, the performance counters are checked too.
module tb_mem_arbiter;

  localparam int NP = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BW = DW / 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0]        req_read, req_write, req_resp;
  logic [NP-1:0][BW-1:0] req_byte_enable;
  logic [NP-1:0][AW-1:0] req_address;
  logic [NP-1:0][DW-1:0] req_wdata;
  logic [DW-1:0]        req_rdata, mem_wdata, mem_rdata;
  logic                 mem_read, mem_write, mem_resp;
  logic [BW-1:0]        mem_byte_enable;
  logic [AW-1:0]        mem_address;
`ifdef MEM_ARBITER_PERF_EN
  logic [NP-1:0][15:0]  grant_count;
  logic [31:0]          busy_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_byte_enable (req_byte_enable),
    .req_address     (req_address),
    .req_wdata       (req_wdata),
    .req_resp        (req_resp),
    .req_rdata       (req_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata)
`ifdef MEM_ARBITER_PERF_EN
    ,
    .grant_count     (grant_count),
    .busy_cycles     (busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b0;
    req_read        = '0;
    req_write       = '0;
    req_byte_enable = '0;
    req_address     = '0;
    req_wdata       = '0;
    mem_resp        = 1'b0;
    mem_rdata       = '0;

    // Reset state
    do_reset();
    chk("rst_mem_read",  32'(mem_read),  32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_req_resp",  32'(req_resp),  32'h0);

    // Single read on port 0, memory answers 3 cycles into BUSY
    req_read[0]    = 1'b1;
    req_address[0] = 16'h1234;
    tick();
    chk("rd_mem_read",  32'(mem_read),    32'h1);
    chk("rd_mem_write", 32'(mem_write),   32'h0);
    chk("rd_mem_addr",  32'(mem_address), 32'h1234);
    chk("rd_no_resp",   32'(req_resp),    32'h0);
    tick();
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 16'hBEEF;
    #1;
    chk("rd_resp",  32'(req_resp),  32'h1);
    chk("rd_rdata", 32'(req_rdata), 32'hBEEF);
    tick();
    mem_resp    = 1'b0;
    req_read[0] = 1'b0;
    chk("rd_idle_mem_read", 32'(mem_read), 32'h0);

    // mem_resp in IDLE is ignored
    mem_resp = 1'b1;
    #1;
    chk("idle_resp_ignored", 32'(req_resp), 32'h0);
    tick();
    mem_resp = 1'b0;
    chk("idle_stays_idle", 32'(mem_read), 32'h0);

    // Contention: ports 0 and 1 continuously after reset -> 0,1,0,1
    do_reset();
    req_read[0]    = 1'b1;
    req_read[1]    = 1'b1;
    req_address[0] = 16'h0100;
    req_address[1] = 16'h0101;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] exp_a;
      logic [3:0]  exp_r;
      exp_a = (k % 2 == 0) ? 16'h0100 : 16'h0101;
      exp_r = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      tick();
      chk("cont_busy", 32'(mem_read),    32'h1);
      chk("cont_addr", 32'(mem_address), 32'(exp_a));
      mem_resp = 1'b1;
      #1;
      chk("cont_resp", 32'(req_resp), 32'(exp_r));
      tick();
      mem_resp = 1'b0;
      chk("cont_idle_gap", 32'(mem_read), 32'h0);
    end
    req_read = '0;

    // Latch integrity: port 1 write, requester changes mid-BUSY
    req_write[1]       = 1'b1;
    req_address[1]     = 16'h2000;
    req_wdata[1]       = 16'h00AA;
    req_byte_enable[1] = 2'b01;
    tick();
    chk("wr_mem_write", 32'(mem_write),       32'h1);
    chk("wr_mem_read",  32'(mem_read),        32'h0);
    chk("wr_addr",      32'(mem_address),     32'h2000);
    chk("wr_wdata",     32'(mem_wdata),       32'h00AA);
    chk("wr_be",        32'(mem_byte_enable), 32'h1);
    req_address[1]     = 16'h3000;
    req_wdata[1]       = 16'hFFFF;
    req_byte_enable[1] = 2'b11;
    req_write[1]       = 1'b0;
    req_read[1]        = 1'b1;
    tick();
    chk("latch_addr",  32'(mem_address),     32'h2000);
    chk("latch_wdata", 32'(mem_wdata),       32'h00AA);
    chk("latch_be",    32'(mem_byte_enable), 32'h1);
    chk("latch_op",    32'(mem_write),       32'h1);
    mem_resp = 1'b1;
    #1;
    chk("latch_addr_at_resp", 32'(mem_address), 32'h2000);
    chk("wr_resp",            32'(req_resp),    32'h2);
    tick();
    mem_resp    = 1'b0;
    req_read[1] = 1'b0;

    // Read and write together on port 0 -> write
    req_read[0]    = 1'b1;
    req_write[0]   = 1'b1;
    req_address[0] = 16'h0040;
    tick();
    chk("rw_mem_write", 32'(mem_write), 32'h1);
    chk("rw_mem_read",  32'(mem_read),  32'h0);
    mem_resp = 1'b1;
    #1;
    chk("rw_resp", 32'(req_resp), 32'h1);
    tick();
    mem_resp  = 1'b0;
    req_read  = '0;
    req_write = '0;

    // Reset mid-BUSY: late mem_resp must not be forwarded
    req_read[1]    = 1'b1;
    req_address[1] = 16'h0555;
    tick();
    chk("mid_busy_read", 32'(mem_read), 32'h1);
    rst         = 1'b1;
    req_read[1] = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_mem_read", 32'(mem_read), 32'h0);
    chk("mid_rst_resp",     32'(req_resp), 32'h0);
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 16'h5A5A;
    #1;
    chk("late_resp_dropped", 32'(req_resp), 32'h0);
    chk("late_mem_read",     32'(mem_read), 32'h0);
    tick();
    mem_resp       = 1'b0;
    req_read[0]    = 1'b1;
    req_read[1]    = 1'b1;
    req_address[0] = 16'h0A00;
    req_address[1] = 16'h0A01;
    tick();
    chk("post_rst_grant_p0", 32'(mem_address), 32'h0A00);
    mem_resp = 1'b1;
    #1;
    chk("post_rst_resp", 32'(req_resp), 32'h1);
    tick();
    mem_resp = 1'b0;
    req_read = '0;

`ifdef MEM_ARBITER_PERF_EN
    // Performance counters: 5 single-cycle grants on port 2
    do_reset();
    chk("perf_rst_busy", busy_cycles, 32'h0);
    req_read[2]    = 1'b1;
    req_address[2] = 16'h0C00;
    for (int k = 0; k < 5; k++) begin
      tick();
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
    end
    req_read[2] = 1'b0;
    tick();
    for (int p = 0; p < NP; p++) begin
      chk("perf_grant_count", 32'(grant_count[p]), (p == 2) ? 32'd5 : 32'd0);
    end
    chk("perf_busy_cycles", busy_cycles, 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
